// File: rtl/flex_down_counter_if.sv
// Control/status bundle for flex_down_counter: load/count controls in, count and status out.
interface flex_down_counter_if #(
  parameter int NUM_CNT_BITS = 4
);
  logic                    clear;
  logic                    load;
  logic [NUM_CNT_BITS-1:0] load_val;
  logic                    count_enable;
  logic                    auto_reload;
  logic [NUM_CNT_BITS-1:0] count_out;
  logic                    zero_flag;
  logic                    busy;

  modport master (
    output clear, load, load_val, count_enable, auto_reload,
    input  count_out, zero_flag, busy
  );

  modport slave (
    input  clear, load, load_val, count_enable, auto_reload,
    output count_out, zero_flag, busy
  );
endinterface

// File: rtl/flex_down_counter.sv
// Loadable down-counter/timer with terminal-count pulse and optional periodic auto-reload.
module flex_down_counter #(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                clk,
  input  logic                n_rst,
  flex_down_counter_if.slave  bus
);
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]              r_state;
  logic [NUM_CNT_BITS-1:0] r_count;
  logic [NUM_CNT_BITS-1:0] r_reload;
  logic                    r_zero;
  logic                    w_terminal;

  assign w_terminal = (r_count == NUM_CNT_BITS'(1));

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state  <= ST_IDLE;
      r_count  <= '0;
      r_reload <= '0;
      r_zero   <= 1'b0;
    end else begin
      r_zero <= 1'b0;
      if (bus.clear) begin
        r_state  <= ST_IDLE;
        r_count  <= '0;
        r_reload <= '0;
      end else if (bus.load) begin
        r_reload <= bus.load_val;
        r_count  <= bus.load_val;
        // A zero load value parks the counter in IDLE without a terminal pulse.
        r_state  <= (bus.load_val != '0) ? ST_RUN : ST_IDLE;
      end else if (r_state == ST_RUN && bus.count_enable) begin
        if (w_terminal) begin
          r_zero <= 1'b1;
          if (bus.auto_reload) begin
            r_count <= r_reload;
          end else begin
            r_count <= '0;
            r_state <= ST_IDLE;
          end
        end else begin
          r_count <= r_count - 1'b1;
        end
      end
    end
  end

  assign bus.count_out = r_count;
  assign bus.zero_flag = r_zero;
  assign bus.busy      = (r_state == ST_RUN);
endmodule

// File: tb/tb_flex_down_counter.sv
// Directed bench for flex_down_counter: vector table plus hand-written multi-cycle sequences.
module tb_flex_down_counter;
  logic clk;
  logic n_rst;

  flex_down_counter_if #(.NUM_CNT_BITS(4)) bus ();

  flex_down_counter #(.NUM_CNT_BITS(4)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       clr;
    logic       ld;
    logic [3:0] val;
    logic       en;
    logic       ar;
    logic [3:0] exp_cnt;
    logic       exp_zero;
    logic       exp_busy;
  } vec_t;

  vec_t vecs[$];
  int n_checks;
  int n_errors;

  task automatic add(input string nm, input logic c, input logic l, input logic [3:0] v,
                     input logic e, input logic a, input logic [3:0] xc, input logic xz,
                     input logic xb);
    vec_t t;
    t.name = nm; t.clr = c; t.ld = l; t.val = v; t.en = e; t.ar = a;
    t.exp_cnt = xc; t.exp_zero = xz; t.exp_busy = xb;
    vecs.push_back(t);
  endtask

  task automatic drive(input logic c, input logic l, input logic [3:0] v,
                       input logic e, input logic a);
    bus.clear = c; bus.load = l; bus.load_val = v; bus.count_enable = e; bus.auto_reload = a;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [3:0] xc, input logic xz, input logic xb);
    n_checks++;
    if (bus.count_out !== xc) begin
      n_errors++;
      $display("FAIL %s count_out: got %0d expected %0d", nm, bus.count_out, xc);
    end
    n_checks++;
    if (bus.zero_flag !== xz) begin
      n_errors++;
      $display("FAIL %s zero_flag: got %0b expected %0b", nm, bus.zero_flag, xz);
    end
    n_checks++;
    if (bus.busy !== xb) begin
      n_errors++;
      $display("FAIL %s busy: got %0b expected %0b", nm, bus.busy, xb);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    drive(0, 0, 4'd0, 0, 0);
    n_rst = 1'b0;
    #12;
    check("reset_init", 4'd0, 1'b0, 1'b0);
    n_rst = 1'b1;
    step();

    //   name            clr ld val  en ar  cnt  z  b
    add("idle_en",       0, 0, 4'd0, 1, 0, 4'd0, 0, 0);
    add("os_load5",      0, 1, 4'd5, 1, 0, 4'd5, 0, 1);
    add("os_4",          0, 0, 4'd0, 1, 0, 4'd4, 0, 1);
    add("os_3",          0, 0, 4'd0, 1, 0, 4'd3, 0, 1);
    add("os_2",          0, 0, 4'd0, 1, 0, 4'd2, 0, 1);
    add("os_1",          0, 0, 4'd0, 1, 0, 4'd1, 0, 1);
    add("os_term",       0, 0, 4'd0, 1, 0, 4'd0, 1, 0);
    add("os_idle",       0, 0, 4'd0, 1, 0, 4'd0, 0, 0);
    add("gate_load4",    0, 1, 4'd4, 0, 0, 4'd4, 0, 1);
    add("gate_h4",       0, 0, 4'd0, 0, 0, 4'd4, 0, 1);
    add("gate_3",        0, 0, 4'd0, 1, 0, 4'd3, 0, 1);
    add("gate_h3",       0, 0, 4'd0, 0, 0, 4'd3, 0, 1);
    add("gate_2",        0, 0, 4'd0, 1, 0, 4'd2, 0, 1);
    add("gate_h2",       0, 0, 4'd0, 0, 0, 4'd2, 0, 1);
    add("gate_1",        0, 0, 4'd0, 1, 0, 4'd1, 0, 1);
    add("gate_h1",       0, 0, 4'd0, 0, 0, 4'd1, 0, 1);
    add("gate_term",     0, 0, 4'd0, 1, 0, 4'd0, 1, 0);
    add("load0_idle",    0, 1, 4'd0, 1, 0, 4'd0, 0, 0);
    add("coll_load2",    0, 1, 4'd2, 1, 0, 4'd2, 0, 1);
    add("coll_1",        0, 0, 4'd0, 1, 0, 4'd1, 0, 1);
    add("coll_ld_term",  0, 1, 4'd7, 1, 0, 4'd7, 0, 1);
    add("coll_6",        0, 0, 4'd0, 1, 0, 4'd6, 0, 1);
    add("coll_clr_ld",   1, 1, 4'd3, 1, 0, 4'd0, 0, 0);
    add("run_load9",     0, 1, 4'd9, 0, 0, 4'd9, 0, 1);
    add("run_load0",     0, 1, 4'd0, 1, 0, 4'd0, 0, 0);
    add("idle_en2",      0, 0, 4'd0, 1, 1, 4'd0, 0, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].clr, vecs[i].ld, vecs[i].val, vecs[i].en, vecs[i].ar);
      step();
      check(vecs[i].name, vecs[i].exp_cnt, vecs[i].exp_zero, vecs[i].exp_busy);
    end

    // Auto-reload: 3,2,1,3,2,1,3 then drop auto_reload for a final one-shot stop.
    drive(0, 1, 4'd3, 1, 1);
    step();
    check("ar_load3", 4'd3, 1'b0, 1'b1);
    drive(0, 0, 4'd0, 1, 1);
    for (int r = 0; r < 2; r++) begin
      step(); check("ar_2", 4'd2, 1'b0, 1'b1);
      step(); check("ar_1", 4'd1, 1'b0, 1'b1);
      step(); check("ar_reload", 4'd3, 1'b1, 1'b1);
    end
    step(); check("ar_2b", 4'd2, 1'b0, 1'b1);
    drive(0, 0, 4'd0, 1, 0);
    step(); check("ar_1b", 4'd1, 1'b0, 1'b1);
    step(); check("ar_stop", 4'd0, 1'b1, 1'b0);

    // Full-scale load: 15 enabled cycles to the terminal pulse.
    drive(0, 1, 4'd15, 1, 0);
    step();
    check("fs_load15", 4'd15, 1'b0, 1'b1);
    drive(0, 0, 4'd0, 1, 0);
    for (int k = 1; k < 15; k++) begin
      step();
      check("fs_count", 4'(15 - k), 1'b0, 1'b1);
    end
    step();
    check("fs_term", 4'd0, 1'b1, 1'b0);

    // Asynchronous reset mid-count, observed before the next clock edge.
    drive(0, 1, 4'd3, 0, 0);
    step();
    check("rst_pre", 4'd3, 1'b0, 1'b1);
    drive(0, 0, 4'd0, 1, 0);
    #2;
    n_rst = 1'b0;
    #1;
    check("rst_async", 4'd0, 1'b0, 1'b0);
    step();
    check("rst_hold", 4'd0, 1'b0, 1'b0);
    n_rst = 1'b1;
    step();
    check("rst_release", 4'd0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
